// File: rtl/amiq_dvcon_red_rx.sv
// Red bus receiver: buffers each {field2,field1,field0} transaction in a small FIFO
// and replays it downstream as three 32-bit beats over valid/ready, with drop statistics.
module amiq_dvcon_red_rx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [31:0]                field0,
  input  logic [31:0]                field1,
  input  logic [31:0]                field2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [1:0]                 out_beat,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [CNT_W-1:0]           rx_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow,
  input  logic                       clr_stats
);

  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

  typedef enum logic [1:0] {
    BEAT0 = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } beat_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [95:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  beat_e             state_q, state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  logic        not_empty;
  logic        hs;
  logic        pop;
  logic        push;
  logic        drop;
  logic [95:0] head;

  assign not_empty = (fill_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign hs        = not_empty & out_ready;
  assign pop       = hs & (state_q == BEAT2);
  // A full FIFO still takes a new entry when the head leaves on the same edge.
  assign push      = valid & ((fill_q != FULL) | pop);
  assign drop      = valid & ~push;

  always_comb begin
    state_d = state_q;
    if (hs) begin
      case (state_q)
        BEAT0:   state_d = BEAT1;
        BEAT1:   state_d = BEAT2;
        default: state_d = BEAT0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // An event in the clearing cycle survives the clear as a count of one.
  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q | drop;
    if (clr_stats) begin
      rx_cnt_d   = push ? CNT_W'(1) : '0;
      drop_cnt_d = drop ? CNT_W'(1) : '0;
      overflow_d = drop;
    end else begin
      if (push) rx_cnt_d   = sat_inc(rx_cnt_q);
      if (drop) drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      state_q    <= BEAT0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {field2, field1, field0};
  end

  // Storage is never reset, so every beat output is gated by occupancy.
  always_comb begin
    out_data = '0;
    if (not_empty) begin
      case (state_q)
        BEAT0:   out_data = head[31:0];
        BEAT1:   out_data = head[63:32];
        default: out_data = head[95:64];
      endcase
    end
  end

  assign out_valid = not_empty;
  assign out_beat  = not_empty ? state_q : 2'd0;
  assign out_last  = not_empty & (state_q == BEAT2);
  assign fill      = fill_q;
  assign rx_cnt    = rx_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_amiq_dvcon_red_rx.sv
// Scoreboard bench for amiq_dvcon_red_rx: a reference model predicts accepts, drops,
// beat sequence and statistics; a narrow-counter instance exercises saturation.
module tb_amiq_dvcon_red_rx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] f0, f1, f2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_beat;
  logic        out_last;
  logic [2:0]  fill;
  logic [15:0] rx_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        clr_stats;

  logic        s_valid, s_ready, s_clr;
  logic        s_out_valid, s_out_last, s_overflow;
  logic [31:0] s_out_data;
  logic [1:0]  s_out_beat;
  logic [1:0]  s_fill;
  logic [3:0]  s_rx_cnt, s_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  amiq_dvcon_red_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .valid(valid),
    .field0(f0), .field1(f1), .field2(f2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beat(out_beat), .out_last(out_last), .fill(fill),
    .rx_cnt(rx_cnt), .drop_cnt(drop_cnt), .overflow(overflow),
    .clr_stats(clr_stats)
  );

  amiq_dvcon_red_rx #(.DEPTH(2), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .valid(s_valid),
    .field0(f0), .field1(f1), .field2(f2),
    .out_valid(s_out_valid), .out_ready(s_ready), .out_data(s_out_data),
    .out_beat(s_out_beat), .out_last(s_out_last), .fill(s_fill),
    .rx_cnt(s_rx_cnt), .drop_cnt(s_drop_cnt), .overflow(s_overflow),
    .clr_stats(s_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, evaluated mid-cycle for the upcoming rising edge.
  logic [95:0] sb_q[$];
  int          mfill = 0;
  int          mbeat = 0;
  logic [15:0] mrx   = '0;
  logic [15:0] mdrop = '0;
  logic        movf  = 1'b0;

  always @(negedge clk) begin
    logic        m_hs, m_pop, m_push, m_drop;
    logic [95:0] head;
    if (rst) begin
      sb_q.delete();
      mfill = 0; mbeat = 0; mrx = '0; mdrop = '0; movf = 1'b0;
    end else begin
      chk("fill", 96'(fill), 96'(mfill));
      chk("rx_cnt", 96'(rx_cnt), 96'(mrx));
      chk("drop_cnt", 96'(drop_cnt), 96'(mdrop));
      chk("overflow", 96'(overflow), 96'(movf));
      if (mfill > 0) begin
        head = sb_q[0];
        chk("out_valid", 96'(out_valid), 96'(1));
        chk("out_data", 96'(out_data), 96'(head[mbeat*32 +: 32]));
        chk("out_beat", 96'(out_beat), 96'(mbeat));
        chk("out_last", 96'(out_last), 96'(mbeat == 2));
      end else begin
        chk("idle_valid", 96'(out_valid), 96'(0));
        chk("idle_data", 96'(out_data), 96'(0));
        chk("idle_beat", 96'(out_beat), 96'(0));
        chk("idle_last", 96'(out_last), 96'(0));
      end
      m_hs   = (mfill > 0) && out_ready;
      m_pop  = m_hs && (mbeat == 2);
      m_push = valid && ((mfill < DEPTH) || m_pop);
      m_drop = valid && !m_push;
      if (m_push) sb_q.push_back({f2, f1, f0});
      if (m_pop) void'(sb_q.pop_front());
      mfill = mfill + int'(m_push) - int'(m_pop);
      if (m_hs) mbeat = (mbeat == 2) ? 0 : mbeat + 1;
      if (clr_stats) begin
        mrx   = m_push ? 16'd1 : 16'd0;
        mdrop = m_drop ? 16'd1 : 16'd0;
        movf  = m_drop;
      end else begin
        if (m_push && mrx != 16'hFFFF) mrx++;
        if (m_drop && mdrop != 16'hFFFF) mdrop++;
        movf = movf | m_drop;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] base);
    valid = 1'b1;
    f0 = base; f1 = base + 32'd1; f2 = base + 32'd2;
    tick();
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    valid = 1'b0;
    out_ready = 1'b1;
    while (fill != 0 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_fill"}, 96'(fill), 96'(0));
    chk({tag, "_sb_empty"}, 96'(sb_q.size()), 96'(0));
  endtask

  initial begin
    logic [15:0] drop_before;
    rst = 1'b1; valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    f0 = '0; f1 = '0; f2 = '0;
    s_valid = 1'b0; s_ready = 1'b0; s_clr = 1'b0;
    tick();
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_out_data", 96'(out_data), 96'(0));
    chk("rst_fill", 96'(fill), 96'(0));
    chk("rst_rx_cnt", 96'(rx_cnt), 96'(0));
    chk("rst_overflow", 96'(overflow), 96'(0));
    rst = 1'b0;
    tick();

    // Single transaction, ready held high
    out_ready = 1'b1;
    valid = 1'b1; f0 = 32'h11111111; f1 = 32'h22222222; f2 = 32'h33333333;
    tick();
    valid = 1'b0;
    chk("single_b0_data", 96'(out_data), 96'h11111111);
    chk("single_b0_last", 96'(out_last), 96'(0));
    tick();
    chk("single_b1_data", 96'(out_data), 96'h22222222);
    chk("single_b1_beat", 96'(out_beat), 96'(1));
    tick();
    chk("single_b2_data", 96'(out_data), 96'h33333333);
    chk("single_b2_last", 96'(out_last), 96'(1));
    tick();
    chk("single_rx_cnt", 96'(rx_cnt), 96'(1));
    chk("single_fill", 96'(fill), 96'(0));

    // Backpressure: four buffered, then ready toggling
    clear_stats();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hB000_0000 + 32'(i * 16));
    valid = 1'b0;
    chk("bp_fill", 96'(fill), 96'(4));
    tick(); tick();
    chk("bp_hold_data", 96'(out_data), 96'hB000_0000);
    for (int n = 0; n < 60 && fill != 0; n++) begin
      out_ready = ~out_ready;
      tick();
    end
    chk("bp_drained", 96'(fill), 96'(0));
    chk("bp_drop_cnt", 96'(drop_cnt), 96'(0));
    chk("bp_rx_cnt", 96'(rx_cnt), 96'(4));

    // Overflow: six back-to-back into a four-entry FIFO
    clear_stats();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(32'hD000_0000 + 32'(i * 16));
    valid = 1'b0;
    chk("ovf_fill", 96'(fill), 96'(4));
    chk("ovf_rx_cnt", 96'(rx_cnt), 96'(4));
    chk("ovf_drop_cnt", 96'(drop_cnt), 96'(2));
    chk("ovf_flag", 96'(overflow), 96'(1));
    drain("ovf_drain");

    // Full FIFO with push coinciding with the final-beat pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hE000_0000 + 32'(i * 16));
    valid = 1'b0;
    drop_before = drop_cnt;
    out_ready = 1'b1;
    tick(); tick();
    chk("fp_at_beat2", 96'(out_beat), 96'(2));
    send(32'hE000_1000);
    valid = 1'b0;
    out_ready = 1'b0;
    chk("fp_fill", 96'(fill), 96'(4));
    chk("fp_drop_cnt", 96'(drop_cnt), 96'(drop_before));
    drain("fp_drain");

    // Asynchronous reset while beat 1 is presented
    out_ready = 1'b1;
    send(32'hA000_0000);
    valid = 1'b0;
    tick();
    chk("mid_at_beat1", 96'(out_beat), 96'(1));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 96'(out_valid), 96'(0));
    chk("mid_rst_data", 96'(out_data), 96'(0));
    chk("mid_rst_beat", 96'(out_beat), 96'(0));
    chk("mid_rst_last", 96'(out_last), 96'(0));
    chk("mid_rst_fill", 96'(fill), 96'(0));
    chk("mid_rst_rx_cnt", 96'(rx_cnt), 96'(0));
    tick();
    rst = 1'b0;
    tick();
    send(32'hA100_0000);
    valid = 1'b0;
    chk("post_rst_beat", 96'(out_beat), 96'(0));
    chk("post_rst_data", 96'(out_data), 96'hA100_0000);
    drain("post_rst_drain");

    // Clear in the same cycle as a drop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hC000_0000 + 32'(i * 16));
    clr_stats = 1'b1;
    send(32'hC000_1000);
    clr_stats = 1'b0;
    valid = 1'b0;
    chk("clr_drop_cnt", 96'(drop_cnt), 96'(1));
    chk("clr_overflow", 96'(overflow), 96'(1));
    chk("clr_rx_cnt", 96'(rx_cnt), 96'(0));
    drain("clr_drain");

    // Saturation on the narrow-counter instance
    s_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      f0 = 32'(i); f1 = 32'(i + 100); f2 = 32'(i + 200);
      tick();
      s_valid = 1'b0;
      tick(); tick();
    end
    chk("sat_rx_cnt", 96'(s_rx_cnt), 96'hF);
    chk("sat_no_drop", 96'(s_drop_cnt), 96'(0));
    s_ready = 1'b0;
    s_valid = 1'b1;
    repeat (22) tick();
    s_valid = 1'b0;
    chk("sat_fill", 96'(s_fill), 96'(2));
    chk("sat_drop_cnt", 96'(s_drop_cnt), 96'hF);
    chk("sat_rx_hold", 96'(s_rx_cnt), 96'hF);
    chk("sat_overflow", 96'(s_overflow), 96'(1));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/amiq_dvcon_red_rx.md
# amiq_dvcon_red_rx

Receiving end of the red VIP bus. Captures every red transaction (`field0`/`field1`/`field2` qualified by `valid`) into a small FIFO and replays each one downstream as three 32-bit beats over a valid/ready handshake. The red bus has no backpressure, so the block also counts accepted and dropped transactions. It sits between the red VIP driver and the DUT core.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, one transaction each. Must be a power of 2 and ≥ 2.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `valid` input 1: red transaction present this cycle.
- `field0` input 32: red field 0.
- `field1` input 32: red field 1.
- `field2` input 32: red field 2.
- `out_valid` output 1: downstream beat valid.
- `out_ready` input 1: downstream accepts the beat.
- `out_data` output 32: beat payload.
- `out_beat` output 2: beat index 0/1/2.
- `out_last` output 1: high on beat 2.
- `fill` output $clog2(DEPTH)+1: current FIFO occupancy.
- `rx_cnt` output CNT_W: transactions accepted, saturating.
- `drop_cnt` output CNT_W: transactions dropped, saturating.
- `overflow` output 1: sticky drop flag.
- `clr_stats` input 1: synchronous clear of `rx_cnt`, `drop_cnt` and `overflow`.

## Operation
- Capture: on each edge with `valid`=1, push {`field2`,`field1`,`field0`} if a slot is free, else drop. No other input qualification.
- Slot free means `fill` < DEPTH, or a pop occurs in the same cycle (final-beat handshake). A full FIFO with a simultaneous pop accepts the push, and `fill` stays at DEPTH.
- Drop: the transaction is discarded, `drop_cnt` increments (saturating at all-ones) and `overflow` is set.
- Accept: `rx_cnt` increments (saturating).
- Beat FSM, states BEAT0 → BEAT1 → BEAT2 → BEAT0:
  - Advances only on a handshake (`out_valid` & `out_ready`).
  - `out_valid` = FIFO not empty.
  - `out_data` = head `field[out_beat]`.
  - `out_beat` = current state encoding (0, 1, 2).
  - `out_last` = (state == BEAT2) & `out_valid`.
- Pop: the head entry is popped on the BEAT2 handshake, and the FSM returns to BEAT0.
- While empty, the FSM holds BEAT0.
- While `out_valid` & !`out_ready`, `out_data`, `out_beat` and `out_last` are held stable.
- `clr_stats`:
  - Clears both counters and `overflow` at the edge.
  - A drop or accept in the same cycle wins over the clear: the counter becomes 1, and `overflow` becomes 1 if the event was a drop.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Reset:
  - Pointers cleared, `fill`=0, FSM=BEAT0.
  - `out_valid`=0, `out_data`=0, `out_beat`=0, `out_last`=0.
  - `rx_cnt`=0, `drop_cnt`=0, `overflow`=0.
  - FIFO storage is not reset. Outputs are gated so stale storage never appears while empty.
- Reset mid-transaction: the partial beat sequence is abandoned. The first post-reset transaction starts at beat 0.

## Timing
- Latency: a `valid` sampled at edge N gives `out_valid`=1 with beat 0 during cycle N+1 (registered FIFO write, head read combinationally from storage).
- Throughput: one transaction per 3 cycles with `out_ready` held high.
- Sustained `valid` every cycle therefore overflows.
- `fill` updates at the edge of the push and/or pop: +1, −1 or unchanged.
- `fill`, counters and `overflow` are registered outputs.
- `out_*` signals are derived from registered state and pointers, with no combinational path from `valid` or `out_ready`.

## Test plan
- Single transaction: `valid` one cycle with field0=0x11111111, field1=0x22222222, field2=0x33333333, `out_ready`=1.
  - Expect beats 0x11111111/0x22222222/0x33333333 in cycles N+1..N+3, `out_last` only on the third.
  - Expect `rx_cnt`=1, `fill` back to 0.
- Backpressure: 4 transactions back-to-back with `out_ready`=0, then `out_ready` toggling.
  - Expect `fill`=4, then data held stable while not ready.
  - Expect 12 beats in order, `drop_cnt`=0.
- Overflow: 6 transactions back-to-back with `out_ready`=0, DEPTH=4.
  - Expect `fill`=4, `rx_cnt`=4, `drop_cnt`=2, `overflow`=1.
  - Entries 5 and 6 never appear downstream.
- Full plus pop: FIFO full, and `valid` arrives in the same cycle as the BEAT2 handshake.
  - Expect the push accepted, `fill` stays 4, `drop_cnt` unchanged.
- Reset mid-burst: assert `rst` asynchronously during beat 1 of a transaction.
  - Expect all outputs 0 immediately.
  - A new transaction after reset is delivered beat 0 first.
- Stats clear: `clr_stats` pulsed in the same cycle as a drop.
  - Expect `drop_cnt`=1, `overflow`=1, `rx_cnt`=0.
  - Expect `rx_cnt` saturation at 0xFFFF with CNT_W=16 by forcing 65536+ accepts.
